// File: rtl/memx_stream_ctrl.sv
// memx_stream_ctrl: streams a block of memX words to an update unit and writes each in-order result back to its source address.
// Define MEMX_STREAM_CTRL_ERR_EN to add a sticky `err` output that flags dropped (stray) results.
module memx_stream_ctrl #(
    parameter int ELEMENT_WIDTH   = 32,
    parameter int NO_OF_UNITS     = 8,
    parameter int ADDRESS_WIDTH   = 20,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [ADDRESS_WIDTH-1:0]             base_address,
    input  logic [ADDRESS_WIDTH-1:0]             length,
    output logic                                 busy,
    output logic                                 done,
    output logic [ADDRESS_WIDTH-1:0]             mem_read_address,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] mem_data,
    output logic                                 mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0]             mem_write_address,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] mem_write_data,
    output logic                                 op_valid,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] op_data,
    input  logic                                 op_ready,
    input  logic                                 res_valid,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] res_data
`ifdef MEMX_STREAM_CTRL_ERR_EN
    ,
    output logic                                 err
`endif
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int W  = NO_OF_UNITS * ELEMENT_WIDTH;
    localparam logic [AW-1:0] ZERO_C    = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_C     = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] MAX_OUT_C = AW'(MAX_OUTSTANDING);
    localparam logic [W-1:0]  ZERO_W_C  = {W{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e        state_r;
    state_e        state_nxt_s;
    logic [AW-1:0] base_r;
    logic [AW-1:0] length_r;
    logic [AW-1:0] issued_r;
    logic [AW-1:0] received_r;
    logic [AW-1:0] outstanding_s;
    logic          start_accept_s;
    logic          op_valid_s;
    logic          op_fire_s;
    logic          res_accept_s;
    logic          last_res_s;
    logic          done_r;
    logic          mem_write_enable_r;
    logic [AW-1:0] mem_write_address_r;
    logic [W-1:0]  mem_write_data_r;

    // Counters never cross: a result is only accepted while something is in flight.
    assign outstanding_s = issued_r - received_r;
    assign op_fire_s     = op_valid_s && op_ready;

    // Next-state, issue qualification and result acceptance.
    always_comb begin
        state_nxt_s    = state_r;
        start_accept_s = 1'b0;
        op_valid_s     = 1'b0;
        res_accept_s   = 1'b0;
        last_res_s     = 1'b0;
        case (state_r)
            IDLE: begin
                start_accept_s = start;
                if (start && (length != ZERO_C)) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                op_valid_s   = (issued_r < length_r) && (outstanding_s < MAX_OUT_C);
                res_accept_s = res_valid && (outstanding_s != ZERO_C);
                last_res_s   = res_accept_s && ((received_r + ONE_C) == length_r);
                if (last_res_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pass context and issue/receive counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r     <= ZERO_C;
            length_r   <= ZERO_C;
            issued_r   <= ZERO_C;
            received_r <= ZERO_C;
        end else if (start_accept_s) begin
            base_r     <= base_address;
            length_r   <= length;
            issued_r   <= ZERO_C;
            received_r <= ZERO_C;
        end else begin
            if (op_fire_s) begin
                issued_r <= issued_r + ONE_C;
            end
            if (res_accept_s) begin
                received_r <= received_r + ONE_C;
            end
        end
    end

    // Registered write-back port and end-of-pass pulse; reset cancels a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_write_enable_r  <= 1'b0;
            mem_write_address_r <= ZERO_C;
            mem_write_data_r    <= ZERO_W_C;
            done_r              <= 1'b0;
        end else begin
            mem_write_enable_r <= res_accept_s;
            done_r             <= last_res_s || (start_accept_s && (length == ZERO_C));
            if (res_accept_s) begin
                mem_write_address_r <= base_r + received_r;
                mem_write_data_r    <= res_data;
            end
        end
    end

`ifdef MEMX_STREAM_CTRL_ERR_EN
    logic err_r;

    // Sticky flag for dropped results; a new pass clears it unless a stray arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (res_valid && !res_accept_s) begin
            err_r <= 1'b1;
        end else if (start_accept_s) begin
            err_r <= 1'b0;
        end
    end

    assign err = err_r;
`endif

    assign busy              = (state_r == RUN);
    assign done              = done_r;
    assign mem_read_address  = base_r + issued_r;
    assign op_valid          = op_valid_s;
    assign op_data           = mem_data;
    assign mem_write_enable  = mem_write_enable_r;
    assign mem_write_address = mem_write_address_r;
    assign mem_write_data    = mem_write_data_r;

endmodule

// File: tb/tb_memx_stream_ctrl.sv
// Testbench for memx_stream_ctrl: directed scenarios plus randomized passes against a queue-based update-unit model.
`timescale 1ns/1ps
module tb_memx_stream_ctrl;
    localparam int AW   = 20;
    localparam int W    = 256;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          reset, start, busy, done, mem_write_enable, op_valid, op_ready, res_valid;
    logic [AW-1:0] base_address, length, mem_read_address, mem_write_address;
    logic [W-1:0]  mem_data, mem_write_data, op_data, res_data;
`ifdef MEMX_STREAM_CTRL_ERR_EN
    logic          err;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] salt   = 32'h0;

    logic [AW-1:0] xfer_addr_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [W-1:0]  xfer_data_q[$];
    logic [W-1:0]  wr_data_q[$];
    int            xfer_cyc_q[$];
    int            wr_cyc_q[$];
    int            done_cyc_q[$];
    int            ov_dev, busy_dev, max_inflight, busy_cnt;

    memx_stream_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .base_address(base_address), .length(length),
        .busy(busy), .done(done),
        .mem_read_address(mem_read_address), .mem_data(mem_data),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
        .res_valid(res_valid), .res_data(res_data)
`ifdef MEMX_STREAM_CTRL_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Read-only memX image: every word is a function of its address and the current salt.
    function automatic logic [W-1:0] pattern(input logic [AW-1:0] a, input logic [31:0] s);
        logic [31:0] e;
        e = {12'h000, a} ^ s;
        return {8{e}};
    endfunction

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    assign mem_data = pattern(mem_read_address, salt);

    // Drives one pass (optionally a second one started at cycle chain_c) with an in-order update unit
    // adding 1 to each word after a random delay, and records what the DUT did.
    task automatic run_pass(input logic [AW-1:0] b, input logic [AW-1:0] n, input int ready_pct,
                            input int max_dly, input logic [AW-1:0] b2, input logic [AW-1:0] n2,
                            input int chain_c);
        logic [W-1:0] rq_data[$];
        int           rq_due[$];
        int           pass_t, pass_r, pass_n, pass_s, n_pass;
        logic         exp_busy, exp_ov;
        xfer_addr_q.delete(); xfer_data_q.delete(); xfer_cyc_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
        ov_dev = 0; busy_dev = 0; max_inflight = 0; busy_cnt = 0;
        pass_t = 0; pass_r = 0; pass_n = int'(n); pass_s = 0;
        n_pass = (chain_c >= 0) ? 2 : 1;
        for (int c = 0; c < 3000; c++) begin
            if (chain_c >= 0 && c == chain_c) begin
                pass_t = 0; pass_r = 0; pass_n = int'(n2); pass_s = c;
            end
            start        = (c == 0) || (c == chain_c);
            base_address = (chain_c >= 0 && c >= chain_c) ? b2 : b;
            length       = (chain_c >= 0 && c >= chain_c) ? n2 : n;
            op_ready     = ($urandom_range(99) < ready_pct);
            if (rq_due.size() > 0 && rq_due[0] <= c) begin
                res_valid = 1'b1;
                res_data  = rq_data.pop_front();
                void'(rq_due.pop_front());
            end else begin
                res_valid = 1'b0;
                res_data  = '0;
            end
            @(negedge clk);
            exp_busy = (c > pass_s) && (pass_r < pass_n);
            exp_ov   = exp_busy && (pass_t < pass_n) && ((pass_t - pass_r) < MAXO);
            if (busy !== exp_busy) busy_dev++;
            if (op_valid !== exp_ov) ov_dev++;
            if (busy) busy_cnt++;
            if (op_valid && op_ready) begin
                xfer_addr_q.push_back(mem_read_address);
                xfer_data_q.push_back(op_data);
                xfer_cyc_q.push_back(c);
                rq_data.push_back(op_data + W'(1));
                rq_due.push_back(c + int'($urandom_range(max_dly, 1)));
                pass_t++;
            end
            if (res_valid) pass_r++;
            if (pass_t - pass_r > max_inflight) max_inflight = pass_t - pass_r;
            if (mem_write_enable) begin
                wr_addr_q.push_back(mem_write_address);
                wr_data_q.push_back(mem_write_data);
                wr_cyc_q.push_back(c);
            end
            if (done) done_cyc_q.push_back(c);
            @(posedge clk); #1;
            if (done_cyc_q.size() >= n_pass && c >= done_cyc_q[done_cyc_q.size()-1] + 2) break;
        end
        start = 1'b0; res_valid = 1'b0; op_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_write_enable, op_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, mem_write_enable, op_valid});
        end
        checks++;
        if (mem_read_address !== 20'h0 || mem_write_address !== 20'h0) begin
            errors++; $display("FAIL reset_addr: got rd=%0h wr=%0h want 0", mem_read_address, mem_write_address);
        end
        checks++;
        if (mem_write_data !== '0) begin
            errors++; $display("FAIL reset_wdata: got %0h want 0", mem_write_data);
        end
`ifdef MEMX_STREAM_CTRL_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b want 0", err);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        salt = $urandom();
        run_pass(20'd10, 20'd3, 100, 1, 20'd0, 20'd0, -1);
        checks++;
        if (wr_addr_q.size() != 3) begin
            errors++; $display("FAIL basic_wr_count: got %0d want 3", wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 3; i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(10 + i) || wr_data_q[i] !== pattern(AW'(10 + i), salt) + W'(1)) begin
                errors++; $display("FAIL basic_write%0d: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i],
                                   AW'(10 + i), pattern(AW'(10 + i), salt) + W'(1));
            end
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 5) begin
            errors++; $display("FAIL basic_done: got count=%0d cycle=%0d want 1 at 5", done_cyc_q.size(), q_at(done_cyc_q, 0));
        end
        checks++;
        if (busy_cnt != 4 || busy_dev != 0 || ov_dev != 0) begin
            errors++; $display("FAIL basic_busy: got busy=%0d dev=%0d/%0d want 4 0/0", busy_cnt, busy_dev, ov_dev);
        end
    endtask

    task automatic test_backpressure();
        int n_x;
        salt = $urandom();
        start = 1'b1; base_address = 20'd100; length = 20'd8; op_ready = 1'b1; res_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; n_x = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (op_valid && op_ready) n_x++;
            @(posedge clk); #1;
        end
        checks++;
        if (n_x != MAXO) begin
            errors++; $display("FAIL bp_transfers: got %0d want %0d", n_x, MAXO);
        end
        res_valid = 1'b1; res_data = pattern(20'd100, salt) + W'(1);
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b0) begin
            errors++; $display("FAIL bp_stalled: got op_valid=%b want 0", op_valid);
        end
        @(posedge clk); #1;
        res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b1) begin
            errors++; $display("FAIL bp_reraise: got op_valid=%b want 1", op_valid);
        end
        checks++;
        if (mem_write_enable !== 1'b1 || mem_write_address !== 20'd100) begin
            errors++; $display("FAIL bp_write: got we=%b addr=%0h want 1 64", mem_write_enable, mem_write_address);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b0) begin
            errors++; $display("FAIL bp_refill: got op_valid=%b want 0", op_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1; op_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_zero_len();
        run_pass(20'd7, 20'd0, 100, 1, 20'd0, 20'd0, -1);
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 1) begin
            errors++; $display("FAIL zero_done: got count=%0d cycle=%0d want 1 at 1", done_cyc_q.size(), q_at(done_cyc_q, 0));
        end
        checks++;
        if (wr_addr_q.size() != 0 || xfer_addr_q.size() != 0 || busy_cnt != 0) begin
            errors++; $display("FAIL zero_quiet: got writes=%0d xfers=%0d busy=%0d want 0", wr_addr_q.size(), xfer_addr_q.size(), busy_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        salt = $urandom();
        run_pass(20'hFFFFE, 20'd4, 100, 1, 20'd0, 20'd0, -1);
        checks++;
        if (wr_addr_q.size() != 4 || xfer_addr_q.size() != 4) begin
            errors++; $display("FAIL wrap_count: got wr=%0d xfer=%0d want 4", wr_addr_q.size(), xfer_addr_q.size());
        end
        for (int i = 0; i < 4 && i < wr_addr_q.size() && i < xfer_addr_q.size(); i++) begin
            ea = 20'hFFFFE + AW'(i);
            checks++;
            if (xfer_addr_q[i] !== ea || wr_addr_q[i] !== ea || wr_data_q[i] !== pattern(ea, salt) + W'(1)) begin
                errors++; $display("FAIL wrap_addr%0d: got rd=%0h wr=%0h want %0h", i, xfer_addr_q[i], wr_addr_q[i], ea);
            end
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 6) begin
            errors++; $display("FAIL wrap_done: got count=%0d cycle=%0d want 1 at 6", done_cyc_q.size(), q_at(done_cyc_q, 0));
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_a[5];
        exp_a = '{20'd30, 20'd31, 20'd32, 20'd31, 20'd32};
        salt = $urandom();
        run_pass(20'd30, 20'd3, 100, 1, 20'd31, 20'd2, 5);
        checks++;
        if (done_cyc_q.size() != 2 || q_at(done_cyc_q, 0) != 5 || q_at(done_cyc_q, 1) != 9) begin
            errors++; $display("FAIL b2b_done: got count=%0d at %0d,%0d want 2 at 5,9", done_cyc_q.size(),
                               q_at(done_cyc_q, 0), q_at(done_cyc_q, 1));
        end
        checks++;
        if (q_at(xfer_cyc_q, 3) != 6) begin
            errors++; $display("FAIL b2b_first_read: got cycle %0d want 6", q_at(xfer_cyc_q, 3));
        end
        checks++;
        if (wr_addr_q.size() != 5) begin
            errors++; $display("FAIL b2b_wr_count: got %0d want 5", wr_addr_q.size());
        end
        for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== pattern(exp_a[i], salt) + W'(1)) begin
                errors++; $display("FAIL b2b_write%0d: got %0h want %0h", i, wr_addr_q[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_stray();
        salt = $urandom();
        start = 1'b1; base_address = 20'd200; length = 20'd2; op_ready = 1'b0; res_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; res_valid = 1'b1; res_data = {8{32'hDEAD_BEEF}};
        @(posedge clk); #1;
        res_valid = 1'b0; op_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL stray_nowrite: got we=%b want 0", mem_write_enable);
        end
`ifdef MEMX_STREAM_CTRL_ERR_EN
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL stray_err: got %b want 1", err);
        end
`endif
        @(posedge clk); #1;
        res_valid = 1'b1; res_data = pattern(20'd200, salt) + W'(7);
        @(posedge clk); #1;
        res_data = pattern(20'd201, salt) + W'(7); op_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_write_enable !== 1'b1 || mem_write_address !== 20'd200 || mem_write_data !== pattern(20'd200, salt) + W'(7)) begin
            errors++; $display("FAIL stray_first_write: got we=%b addr=%0h want 1 c8", mem_write_enable, mem_write_address);
        end
        @(posedge clk); #1;
        res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_write_enable !== 1'b1 || mem_write_address !== 20'd201 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL stray_last_write: got we=%b addr=%0h done=%b busy=%b want 1 c9 1 0",
                               mem_write_enable, mem_write_address, done, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midpass();
        start = 1'b1; base_address = 20'd50; length = 20'd6; op_ready = 1'b1; res_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        op_ready = 1'b0; res_valid = 1'b1; res_data = {8{32'h1234_5678}}; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_write_enable, op_valid} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_flags: got %b want 0000", {busy, done, mem_write_enable, op_valid});
        end
        checks++;
        if (mem_read_address !== 20'h0 || mem_write_address !== 20'h0 || mem_write_data !== '0) begin
            errors++; $display("FAIL rst_mid_port: got rd=%0h wr=%0h data=%0h want 0", mem_read_address, mem_write_address, mem_write_data);
        end
        @(posedge clk); #1;
        salt = $urandom();
        run_pass(20'd0, 20'd1, 100, 1, 20'd0, 20'd0, -1);
        checks++;
        if (wr_addr_q.size() != 1 || q_at(done_cyc_q, 0) != 3 || wr_data_q[0] !== pattern(20'd0, salt) + W'(1)) begin
            errors++; $display("FAIL rst_mid_rerun: got writes=%0d done=%0d want 1 at 3", wr_addr_q.size(), q_at(done_cyc_q, 0));
        end
    endtask

`ifdef MEMX_STREAM_CTRL_ERR_EN
    task automatic test_err();
        res_valid = 1'b1; res_data = {8{32'hCAFE_F00D}};
        @(posedge clk); #1;
        res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL err_set: got err=%b we=%b want 1 0", err, mem_write_enable);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %b want 1", err);
        end
        @(posedge clk); #1;
        run_pass(20'd5, 20'd2, 100, 1, 20'd0, 20'd0, -1);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %b want 0", err);
        end
    endtask
`endif

    task automatic test_random();
        logic [AW-1:0] b, n, ea;
        for (int k = 0; k < 6; k++) begin
            salt = $urandom();
            b    = (k == 0) ? 20'hFFFF8 : AW'($urandom());
            n    = AW'($urandom_range(20, 1));
            run_pass(b, n, int'($urandom_range(100, 30)), int'($urandom_range(6, 1)), 20'd0, 20'd0, -1);
            checks++;
            if (wr_addr_q.size() != int'(n) || xfer_addr_q.size() != int'(n)) begin
                errors++; $display("FAIL rand%0d_count: got wr=%0d xfer=%0d want %0d", k, wr_addr_q.size(), xfer_addr_q.size(), n);
            end
            for (int i = 0; i < int'(n) && i < wr_addr_q.size() && i < xfer_addr_q.size(); i++) begin
                ea = b + AW'(i);
                checks++;
                if (xfer_addr_q[i] !== ea || xfer_data_q[i] !== pattern(ea, salt) ||
                    wr_addr_q[i] !== ea || wr_data_q[i] !== pattern(ea, salt) + W'(1)) begin
                    errors++; $display("FAIL rand%0d_word%0d: got rd=%0h wr=%0h want %0h", k, i, xfer_addr_q[i], wr_addr_q[i], ea);
                end
            end
            checks++;
            if (done_cyc_q.size() != 1 || q_at(done_cyc_q, 0) != q_at(wr_cyc_q, wr_cyc_q.size() - 1)) begin
                errors++; $display("FAIL rand%0d_done: got count=%0d at %0d want 1 at last write", k, done_cyc_q.size(), q_at(done_cyc_q, 0));
            end
            checks++;
            if (ov_dev != 0 || busy_dev != 0 || max_inflight > MAXO) begin
                errors++; $display("FAIL rand%0d_flow: got op_valid_dev=%0d busy_dev=%0d inflight=%0d want 0 0 <=%0d",
                                   k, ov_dev, busy_dev, max_inflight, MAXO);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_address = '0; length = '0;
        op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_back_to_back();
        test_stray();
        test_reset_midpass();
`ifdef MEMX_STREAM_CTRL_ERR_EN
        test_err();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memx_stream_ctrl.md
# memx_stream_ctrl

Sequencer that owns the memX vector memory during an update pass. It streams a block of `length` consecutive wide words, starting at `base_address`, out of memX to an external update unit over a valid/ready handshake. It accepts the unit's in-order results and writes each one back to the address it came from, while capping the number of words in flight. It sits between the iteration control FSM (start/done) and memX (read address, write port).

## Interface
- `ELEMENT_WIDTH`, 32: bits per element.
- `NO_OF_UNITS`, 8: elements per memory word; word width W = `NO_OF_UNITS*ELEMENT_WIDTH`.
- `ADDRESS_WIDTH`, 20: memX address width; also the width of the length and counters.
- `MAX_OUTSTANDING`, 4: maximum words issued to the update unit whose result has not yet been received; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a pass; sampled only in IDLE.
- `base_address` in ADDRESS_WIDTH: first word address; captured on start.
- `length` in ADDRESS_WIDTH: number of words in the pass; captured on start.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse at the end of a pass.
- `mem_read_address` out ADDRESS_WIDTH: drives memX read address. memX read data is combinational, same cycle.
- `mem_data` in W: memX read output.
- `mem_write_enable` out 1: memX write enable.
- `mem_write_address` out ADDRESS_WIDTH: memX write address.
- `mem_write_data` out W: memX write data.
- `op_valid` out 1: word offered to the update unit.
- `op_data` out W: equal to `mem_data`.
- `op_ready` in 1: update unit accepts; a transfer occurs when `op_valid && op_ready`.
- `res_valid` in 1: result present. There is no backpressure; results are always taken.
- `res_data` in W: result word. Results return in issue order.

## Operation
State machine: IDLE, RUN.

IDLE:
- On `start`, capture base and length, and clear the `issued`, `received` and `outstanding` counters.
- If length != 0, go to RUN next cycle.
- If length == 0, stay in IDLE and pulse `done` the next cycle. No memory access occurs.

RUN:
- `mem_read_address` = base + issued, modulo 2^ADDRESS_WIDTH.
- `op_valid` = (issued < length) && (outstanding < MAX_OUTSTANDING). This is combinational from registered state.
- On an op transfer, issued increments.
- On `res_valid`, received increments. The write port is registered with address = base + received and data = `res_data`, and `mem_write_enable` = 1 in the next cycle.
- outstanding = issued − received. A transfer and a result in the same cycle leave it unchanged.
- When a result is accepted with received+1 == length, the next state is IDLE. `done` is 1 and `busy` is 0 in the cycle that carries the final write.
- `start` is ignored while in RUN.

Stray results:
- A `res_valid` with outstanding == 0, or while in IDLE, is dropped.
- A stray result produces no write and does not change the counters.

Addresses wrap modulo 2^ADDRESS_WIDTH. Range checking against memory depth is the caller's responsibility.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_write_enable`=0, `op_valid`=0, `mem_write_address`=0, `mem_write_data`=0, `mem_read_address`=0. Counters are 0 and the state is IDLE.
- Reset during RUN aborts the pass. A write registered in that same cycle is cancelled, so `mem_write_enable`=0 in the cycle after reset.
- Latency from `start` to the first `op_valid`: 1 cycle.
- Latency from `res_valid` to `mem_write_enable`: 1 cycle, so the write commits at the end of that cycle.
- Minimum pass length is length + 2 cycles, achieved with `op_ready`=1 and results returned the cycle after issue.
- A `start` in the `done` cycle is accepted. The new pass's first read occurs after the final write has committed.

## Configuration
- `MEMX_STREAM_CTRL_ERR_EN` defined: adds output `err` (1 bit, reset 0).
  - `err` is sticky; it is set the cycle after any stray result.
  - It is cleared only by `reset` or an accepted `start`.
- Undefined: no `err` port. Stray results are dropped silently, with the behaviour otherwise identical.

## Test plan
- base=10, length=3, `op_ready`=1, each result = op word + 1 returned the next cycle:
  - writes occur to 10, 11, 12 with the incremented data;
  - `done` pulses once, 5 cycles after start;
  - `busy` is high for 4 cycles.
- MAX_OUTSTANDING=4, length=8, unit withholds results:
  - exactly 4 transfers occur, then `op_valid`=0;
  - releasing one result re-raises `op_valid` the next cycle.
- length=0: `done` the cycle after start, no `mem_write_enable`, `busy` never high.
- base=2^20−2, length=4:
  - read and write addresses follow FFFFE, FFFFF, 0, 1;
  - final `done` is correct.
- `reset` asserted with 2 outstanding and `res_valid` high:
  - the next cycle shows all outputs 0 and state IDLE;
  - a following start with base=0, length=1 completes normally.
- With `MEMX_STREAM_CTRL_ERR_EN`: `res_valid` pulse in IDLE sets `err`=1 with no write; the next accepted `start` clears it.
